div_period_meter: RTL and testbench

Measures the high time, low time and full period of the divided clock produced by the programmable clock divider stage, in system `clk` cycles. Sits directly downstream of the divider: its `div_in` input is the divider's `out`. Results are presented on a valid/ready handshake so a controller or display stage can read the actual divided frequency and confirm the programmed ratio.

---
 rtl/div_period_meter.sv | 193 +++++++++++++++++++
 tb/tb_div_period_meter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_period_meter.sv
// div_period_meter
// Measures the high time, low time and full period of the divided clock
// coming out of the programmable divider, counted in system clk cycles.
// A finished measurement (or a timed-out partial one) is offered on a
// valid/ready handshake and held stable until the consumer takes it.
module div_period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HIGH,
    LOW,
    DONE
  } state_t;

  // Timer value on which the next quiet cycle counts as an expiry.
  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;
  logic             expired;
  logic             handshake;
  logic [CNT_W:0]   cap_period;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] tmr;
  state_t           state;

  // Two-flop synchronizer for the asynchronous divided clock plus a history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= div_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise       = s2 & ~s3;
  assign fall       = ~s2 & s3;
  assign expired    = (tmr == TMR_LAST);
  assign handshake  = meas_valid & meas_ready;
  assign cap_period = {1'b0, hcnt} + {1'b0, lcnt};

  // Measurement FSM; results, valid and busy are all registered here so the consumer sees glitch-free outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      lcnt       <= '0;
      tmr        <= '0;
      meas_valid <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= ARM;
            busy  <= 1'b1;
            hcnt  <= '0;
            lcnt  <= '0;
            tmr   <= '0;
          end
        end

        ARM: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rise) begin
            state <= HIGH;
            hcnt  <= CNT_ONE;
            tmr   <= '0;
          end else if (fall) begin
            tmr <= '0;
          end else if (expired) begin
            state      <= DONE;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
            high_cnt   <= hcnt;
            low_cnt    <= lcnt;
            period     <= cap_period;
            timeout    <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        HIGH: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (fall) begin
            state <= LOW;
            lcnt  <= CNT_ONE;
            tmr   <= '0;
          end else if (rise) begin
            tmr <= '0;
          end else if (expired) begin
            state      <= DONE;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
            high_cnt   <= hcnt;
            low_cnt    <= lcnt;
            period     <= cap_period;
            timeout    <= 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
            tmr  <= tmr + 1'b1;
          end
        end

        LOW: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rise) begin
            state      <= DONE;
            busy       <= 1'b0;
            tmr        <= '0;
            meas_valid <= 1'b1;
            high_cnt   <= hcnt;
            low_cnt    <= lcnt;
            period     <= cap_period;
            timeout    <= 1'b0;
          end else if (fall) begin
            tmr <= '0;
          end else if (expired) begin
            state      <= DONE;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
            high_cnt   <= hcnt;
            low_cnt    <= lcnt;
            period     <= cap_period;
            timeout    <= 1'b1;
          end else begin
            lcnt <= lcnt + 1'b1;
            tmr  <= tmr + 1'b1;
          end
        end

        DONE: begin
          // Edges seen here are dropped on purpose: the closing rise is consumed
          if (handshake) begin
            meas_valid <= 1'b0;
            if (en) begin
              state <= ARM;
              busy  <= 1'b1;
              hcnt  <= '0;
              lcnt  <= '0;
              tmr   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          meas_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_period_meter.sv
// tb_div_period_meter
// Self-checking bench for div_period_meter. Stimulus waveforms are built as
// arrays of per-cycle div_in samples; the expected results come from
// searching those arrays for the rise/fall/rise triple that the meter should
// catch after each arming point.
module tb_div_period_meter;

  localparam int CNT_W  = 16;
  localparam int TMO    = 50;
  localparam int WAVE_N = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_in;
  logic             meas_ready;
  logic             meas_valid;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period;
  logic             timeout;
  logic             busy;

  int   vectors = 0;
  int   errors  = 0;
  logic wave [WAVE_N];

  div_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .period     (period),
    .timeout    (timeout),
    .busy       (busy)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic v, input int h, input int l,
                             input logic t, input logic b);
    checkOutput({tag, ".valid"},   32'(meas_valid), 32'(v));
    checkOutput({tag, ".high"},    32'(high_cnt),   h);
    checkOutput({tag, ".low"},     32'(low_cnt),    l);
    checkOutput({tag, ".period"},  32'(period),     h + l);
    checkOutput({tag, ".timeout"}, 32'(timeout),    32'(t));
    checkOutput({tag, ".busy"},    32'(busy),       32'(b));
  endtask

  // Drive one cycle's inputs at the falling edge; outputs then reflect the previous rising edge
  task automatic applyStimulus(input logic e, input logic d, input logic r);
    @(negedge clk);
    en         = e;
    div_in     = d;
    meas_ready = r;
  endtask

  task automatic settle();
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic buildWave(input int lead, input int hmin, input int hmax,
                           input int lmin, input int lmax);
    int n;
    int len;
    for (int i = 0; i < WAVE_N; i++) wave[i] = 1'b0;
    n = lead;
    while (n < WAVE_N) begin
      len = int'($urandom_range(hmax, hmin));
      for (int i = 0; i < len && n < WAVE_N; i++) begin
        wave[n] = 1'b1;
        n++;
      end
      n += int'($urandom_range(lmax, lmin));
    end
  endtask

  // First full high/low period whose opening rise lies at or after sample 'from'
  function automatic bit nextPeriod(input int from, output int r, output int f, output int r2);
    r  = -1;
    f  = -1;
    r2 = -1;
    for (int i = (from < 1) ? 1 : from; i < WAVE_N; i++)
      if (wave[i] && !wave[i-1]) begin
        r = i;
        break;
      end
    if (r < 0) return 1'b0;
    for (int i = r + 1; i < WAVE_N; i++)
      if (!wave[i]) begin
        f = i;
        break;
      end
    if (f < 0) return 1'b0;
    for (int i = f + 1; i < WAVE_N; i++)
      if (wave[i]) begin
        r2 = i;
        break;
      end
    return (r2 >= 0);
  endfunction

  // Play the current wave with en=1 from IDLE; after each result the consumer waits d cycles before taking it
  task automatic runWave(input string tag, input int nres, input int dmin, input int dmax);
    int  arm;
    int  n;
    int  r;
    int  f;
    int  r2;
    int  v;
    int  d;
    int  hs;
    int  p;
    bit  ok;
    arm = 0;
    n   = 0;
    for (int k = 0; k < nres; k++) begin
      ok = nextPeriod(arm - 1, r, f, r2);
      if (!ok) break;
      v  = r2 + 2;
      d  = int'($urandom_range(dmax, dmin));
      hs = v + d + 1;
      if (hs >= WAVE_N) break;
      while (n <= hs) begin
        applyStimulus(1'b1, wave[n], n == hs);
        p = n - 1;
        if (p >= 0) begin
          if (p >= v) begin
            checkResult($sformatf("%s.r%0d", tag, k), 1'b1, f - r, r2 - f, 1'b0, 1'b0);
          end else begin
            checkOutput({tag, ".valid_low"}, 32'(meas_valid), 0);
            checkOutput({tag, ".busy_high"}, 32'(busy), 1);
          end
        end
        n++;
      end
      arm = hs;
    end
    settle();
  endtask

  // Hold div_in at a fixed level (optionally rising at sample rise_at) until the edge timer aborts
  task automatic runStuck(input string tag, input int rise_at, input int valid_at, input int exp_high);
    logic lvl;
    lvl = (rise_at >= 0);
    for (int n = 0; n <= valid_at; n++) begin
      applyStimulus(1'b1, (rise_at >= 0) && (n >= rise_at), 1'b0);
      if (n >= 1) begin
        checkOutput({tag, ".valid_low"}, 32'(meas_valid), 0);
        checkOutput({tag, ".busy_high"}, 32'(busy), 1);
      end
    end
    repeat (3) begin
      applyStimulus(1'b1, lvl, 1'b0);
      checkResult(tag, 1'b1, exp_high, 0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, lvl, 1'b1);
    checkResult({tag, ".held"}, 1'b1, exp_high, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({tag, ".valid_drop"}, 32'(meas_valid), 0);
    checkOutput({tag, ".idle_busy"},  32'(busy), 0);
    settle();
  endtask

  initial begin
    int r;
    int f;
    int r2;
    bit ok;

    rst        = 1'b1;
    en         = 1'b0;
    div_in     = 1'b0;
    meas_ready = 1'b0;

    // Reset, then disabled with a toggling input
    @(negedge clk);
    div_in = 1'b1;
    @(negedge clk);
    checkResult("reset", 1'b0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int n = 0; n < 100; n++) begin
      applyStimulus(1'b0, n[1], 1'($urandom));
      checkResult("disabled", 1'b0, 0, 0, 1'b0, 1'b0);
    end
    settle();

    $display("[TB] basic 4/6 measurement");
    buildWave(6, 4, 4, 6, 6);
    runWave("basic", 4, 0, 0);

    $display("[TB] backpressure");
    buildWave(6, 4, 4, 6, 6);
    runWave("bkpr", 3, 20, 20);

    $display("[TB] timeouts");
    runStuck("tmo_low", -1, TMO, 0);
    runStuck("tmo_high", 2, TMO + 4, TMO);

    $display("[TB] enable drop during HIGH");
    for (int n = 0; n <= 6; n++) begin
      applyStimulus(n != 6, n >= 2, 1'b0);
      if (n >= 5) checkOutput("endrop.busy_high", 32'(busy), 1);
    end
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b0, n[2], 1'b0);
      checkOutput("endrop.busy_low",  32'(busy), 0);
      checkOutput("endrop.no_result", 32'(meas_valid), 0);
    end
    settle();
    buildWave(5, 3, 3, 5, 5);
    runWave("en35", 3, 0, 0);

    $display("[TB] reset during a held result");
    buildWave(6, 4, 4, 6, 6);
    ok = nextPeriod(0, r, f, r2);
    for (int n = 0; n <= r2 + 4; n++) applyStimulus(1'b1, wave[n], 1'b0);
    checkResult("pre_rst", 1'b1, f - r, r2 - f, 1'b0, 1'b0);
    applyStimulus(1'b1, wave[r2 + 5], 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkResult("mid_rst", 1'b0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    settle();
    buildWave(6, 4, 4, 6, 6);
    runWave("post_rst", 2, 0, 0);

    $display("[TB] randomized periods and backpressure");
    for (int k = 0; k < 3; k++) begin
      buildWave(int'($urandom_range(20, 1)), 1, 20, 1, 20);
      runWave($sformatf("rand%0d", k), 15, 0, 25);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
